// File: rtl/coin_start_sequencer.sv
// Frame-timed coin/start pulse sequencer for dkong_top; define COIN_START_SEQ_FREEPLAY_EN to skip coins.
// Outputs registered, change two cycles after a request edge; requests while busy are dropped.
module coin_start_sequencer #(
  parameter int unsigned COIN_FRAMES    = 4,
  parameter int unsigned GAP_FRAMES     = 30,
  parameter int unsigned START_FRAMES   = 4,
  parameter int unsigned HOLDOFF_FRAMES = 60
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic vblank,
  input  logic req_start1,
  input  logic req_start2,
  input  logic coin_manual,
  output logic coin_n,
  output logic start1_n,
  output logic start2_n,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    COIN,
    GAP,
    START,
    HOLD
  } state_t;

  localparam logic [7:0] COIN_LAST  = 8'(COIN_FRAMES - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_FRAMES - 1);
  localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF_FRAMES - 1);

  state_t     state;
  state_t     state_nxt;
  logic       vblank_q;
  logic       req1_q;
  logic       req2_q;
  logic       tick;
  logic       rise1;
  logic       rise2;
  logic       player2;
  logic       player2_nxt;
  logic [1:0] credits;
  logic [1:0] credits_nxt;
  logic [7:0] fcnt;

  assign tick  = vblank & ~vblank_q;
  assign rise1 = req_start1 & ~req1_q;
  assign rise2 = req_start2 & ~req2_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_q <= 1'b0;
      req1_q   <= 1'b0;
      req2_q   <= 1'b0;
    end else begin
      vblank_q <= vblank;
      req1_q   <= req_start1;
      req2_q   <= req_start2;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      player2 <= 1'b0;
      credits <= 2'd0;
      fcnt    <= 8'd0;
    end else begin
      state   <= state_nxt;
      player2 <= player2_nxt;
      credits <= credits_nxt;
      // Each state runs from entry to its Nth tick, so the first frame is partial
      if (state_nxt != state) begin
        fcnt <= 8'd0;
      end else if (tick) begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    player2_nxt = player2;
    credits_nxt = credits;
    case (state)
      IDLE: begin
        if (rise1 | rise2) begin
          player2_nxt = rise2;
          credits_nxt = rise2 ? 2'd2 : 2'd1;
`ifdef COIN_START_SEQ_FREEPLAY_EN
          state_nxt   = START;
`else
          state_nxt   = COIN;
`endif
        end
      end
      COIN: begin
        if (tick && fcnt == COIN_LAST) begin
          credits_nxt = credits - 2'd1;
          state_nxt   = GAP;
        end
      end
      GAP: begin
        if (tick && fcnt == GAP_LAST) begin
          state_nxt = (credits != 2'd0) ? COIN : START;
        end
      end
      START: begin
        if (tick && fcnt == START_LAST) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (tick && fcnt == HOLD_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The manual coin button is registered here and bypasses the FSM entirely
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      coin_n   <= 1'b1;
      start1_n <= 1'b1;
      start2_n <= 1'b1;
      busy     <= 1'b0;
    end else begin
      coin_n   <= ~((state == COIN) | coin_manual);
      start1_n <= ~((state == START) & ~player2);
      start2_n <= ~((state == START) & player2);
      busy     <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_coin_start_sequencer.sv
// Scoreboard bench: stimulus pushes timed output-change events; the monitor pops them as outputs change.
module tb_coin_start_sequencer;

  localparam int F       = 16;
  localparam int COIN_F  = 4;
  localparam int GAP_F   = 30;
  localparam int START_F = 4;
  localparam int HOLD_F  = 60;

  typedef struct {
    int         edge_n;
    logic [3:0] vec;
  } ev_t;

  logic clk;
  logic reset;
  logic vblank;
  logic req_start1;
  logic req_start2;
  logic coin_manual;
  logic coin_n;
  logic start1_n;
  logic start2_n;
  logic busy;
  logic [3:0] vec;

  int  cyc = 0;
  int  checks = 0;
  int  passes = 0;
  bit  stim_done = 0;
  int  seq_mid;
  int  seq_hold_s;
  int  seq_end;
  ev_t exp_q[$];

  coin_start_sequencer dut (
    .clk_sys    (clk),
    .reset      (reset),
    .vblank     (vblank),
    .req_start1 (req_start1),
    .req_start2 (req_start2),
    .coin_manual(coin_manual),
    .coin_n     (coin_n),
    .start1_n   (start1_n),
    .start2_n   (start2_n),
    .busy       (busy)
  );

  // {busy, coin_n, start1_n, start2_n}
  assign vec = {busy, coin_n, start1_n, start2_n};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // vblank high for the last 4 cycles of each F-cycle frame; tick lands on edges with edge % F == F-3
  initial begin
    vblank = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vblank = ((cyc % F) >= F - 4);
    end
  end

  function automatic int nth_tick(input int s, input int n);
    int t;
    t = s + 1;
    while (t % F != F - 3) t++;
    return t + (n - 1) * F;
  endfunction

  task automatic push_ev(input int e, input logic [3:0] v);
    ev_t x;
    int  i;
    x.edge_n = e;
    x.vec    = v;
    i = 0;
    while (i < exp_q.size() && exp_q[i].edge_n <= e) i++;
    exp_q.insert(i, x);
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Raise the requests for two cycles and queue every output change of the full sequence
  task automatic issue(input logic p1, input logic p2);
    int s;
    int e;
    int credits;
    logic [1:0] st;
    next_cycle();
    req_start1 = p1;
    req_start2 = p2;
    s = cyc + 1;
    st = p2 ? 2'b10 : 2'b01;
    credits = p2 ? 2 : 1;
    e = s;
`ifdef COIN_START_SEQ_FREEPLAY_EN
    push_ev(s + 1, {2'b11, st});
`else
    push_ev(s + 1, 4'b1011);
    for (int c = 1; c <= credits; c++) begin
      e = nth_tick(e, COIN_F);
      push_ev(e + 1, 4'b1111);
      if (c == 1) seq_mid = e + 10;
      e = nth_tick(e, GAP_F);
      push_ev(e + 1, (c < credits) ? 4'b1011 : {2'b11, st});
    end
`endif
    e = nth_tick(e, START_F);
    push_ev(e + 1, 4'b1111);
    seq_hold_s = e;
`ifdef COIN_START_SEQ_FREEPLAY_EN
    seq_mid = e + 10;
`endif
    e = nth_tick(e, HOLD_F);
    push_ev(e + 1, 4'b0111);
    seq_end = e + 1;
    next_cycle();
    next_cycle();
    req_start1 = 1'b0;
    req_start2 = 1'b0;
  endtask

  task automatic pulse_coin_manual(input logic [3:0] on_vec, input logic [3:0] off_vec);
    next_cycle();
    coin_manual = 1'b1;
    push_ev(cyc + 1, on_vec);
    repeat (3) next_cycle();
    coin_manual = 1'b0;
    push_ev(cyc + 1, off_vec);
  endtask

  // Stimulus
  initial begin
    int s;
    reset       = 1'b1;
    req_start1  = 1'b0;
    req_start2  = 1'b0;
    coin_manual = 1'b0;
    repeat (3) next_cycle();
    reset = 1'b0;

    // Manual coin while idle
    pulse_coin_manual(4'b0011, 4'b0111);
    repeat (5) next_cycle();

    // 1P sequence with a manual coin press during HOLD
    issue(1'b1, 1'b0);
    wait_until(seq_hold_s + 10);
    pulse_coin_manual(4'b1011, 4'b1111);
    wait_until(seq_end + 5);

    // 2P sequence
    issue(1'b0, 1'b1);
    wait_until(seq_end + 5);

    // Simultaneous requests: 2P wins
    issue(1'b1, 1'b1);
    wait_until(seq_end + 5);

    // Requests while busy are dropped; a level held past HOLD does not retrigger
    issue(1'b1, 1'b0);
    wait_until(seq_mid);
    req_start1 = 1'b1;
    next_cycle();
    next_cycle();
    req_start1 = 1'b0;
    wait_until(seq_hold_s + 20);
    req_start1 = 1'b1;
    wait_until(seq_end + 20);
    req_start1 = 1'b0;
    repeat (3) next_cycle();
    issue(1'b1, 1'b0);
    wait_until(seq_end + 5);

    // Reset in the first state of a sequence, then a full restart
    next_cycle();
    req_start1 = 1'b1;
    s = cyc + 1;
`ifdef COIN_START_SEQ_FREEPLAY_EN
    push_ev(s + 1, 4'b1101);
`else
    push_ev(s + 1, 4'b1011);
`endif
    wait_until(s + 6);
    reset = 1'b1;
    req_start1 = 1'b0;
    push_ev(cyc + 1, 4'b0111);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    repeat (5) next_cycle();
    issue(1'b1, 1'b0);
    wait_until(seq_end + 5);

    stim_done = 1'b1;
  end

  // Monitor / scoreboard: owns all counters and the summary
  initial begin
    logic [3:0] prev;
    ev_t ev;
    repeat (3) @(negedge clk);
    checks++;
    if (vec === 4'b0111) passes++;
    else $display("FAIL reset_state: got %b required 0111", vec);
    prev = 4'b0111;
    while (!stim_done) begin
      @(negedge clk);
      if (vec !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_change at edge %0d: got %b required %b", cyc, vec, prev);
        end else begin
          ev = exp_q.pop_front();
          checks++;
          if (vec === ev.vec) passes++;
          else $display("FAIL event_value at edge %0d: got %b required %b", cyc, vec, ev.vec);
          checks++;
          if (cyc == ev.edge_n) passes++;
          else $display("FAIL event_time for %b: got edge %0d required edge %0d", ev.vec, cyc, ev.edge_n);
        end
        prev = vec;
      end
    end
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL pending_events: got %0d left required 0 (next %b at edge %0d)",
                  exp_q.size(), exp_q[0].vec, exp_q[0].edge_n);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
